// File: rtl/wb_arb_pkg.sv
// Shared widths, state encoding and sizing helpers for the round-robin Wishbone arbiter.
// RTL and benches import this package so their default geometry always agrees.
package wb_arb_pkg;

  localparam int unsigned WB_NUM_MASTERS = 2;
  localparam int unsigned WB_ADDR_WIDTH  = 16;
  localparam int unsigned WB_DATA_WIDTH  = 32;
  localparam int unsigned WB_GRANULE     = 8;
  localparam int unsigned WB_TIMEOUT     = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned sel_width(input int unsigned data_width,
                                            input int unsigned granule);
    return data_width / granule;
  endfunction

  // A one-bit index is kept even for a single master so port slices stay legal.
  function automatic int unsigned idx_width(input int unsigned num_masters);
    return (num_masters > 1) ? $clog2(num_masters) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin selector: first set request bit scanning upward from
// last+1 (wrapping), returned both one-hot and as a binary index.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = WB_NUM_MASTERS,
  parameter int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   valid
);

  logic [IDX_W-1:0] cand;

  // Offset 1..NUM_MASTERS so the previous owner is considered last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone B4 classic arbiter sharing one slave between NUM_MASTERS masters.
// Optional slave-ack timeout with per-master error pulse: define WB_ARB_TIMEOUT_EN.
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS = WB_NUM_MASTERS,
  parameter  int unsigned ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter  int unsigned DATA_WIDTH  = WB_DATA_WIDTH,
  parameter  int unsigned GRANULE     = WB_GRANULE,
  parameter  int unsigned TIMEOUT     = WB_TIMEOUT,
  localparam int unsigned SEL_WIDTH   = sel_width(DATA_WIDTH, GRANULE)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            gnt_o
`ifdef WB_ARB_TIMEOUT_EN
  ,
  output logic [NUM_MASTERS-1:0]            m_err_o
`endif
);

  localparam int unsigned IDX_W = idx_width(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("wb_arbiter_rr: NUM_MASTERS must be in 2..8");
  end
  if (GRANULE == 0 || (DATA_WIDTH % GRANULE) != 0 || TIMEOUT < 1) begin : g_bad_geometry
    $error("wb_arbiter_rr: DATA_WIDTH must be a multiple of GRANULE and TIMEOUT >= 1");
  end

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       last_q;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;

  logic busy;
  logic owner_cyc;
  logic owner_stb;
  logic abort;
  logic bus_on;

  wb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req     (m_cyc_i),
    .last    (last_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .valid   (pick_valid)
  );

  assign busy      = (state_q == BUSY);
  assign owner_cyc = m_cyc_i[idx_q];
  assign owner_stb = m_stb_i[idx_q];
  assign bus_on    = busy & owner_cyc & ~abort;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter is registered so abort never depends combinationally on s_ack_i.
  assign abort = busy && (tmo_cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk_i) begin
    if (rst_i || !busy || s_ack_i) begin
      tmo_cnt_q <= '0;
    end else if (s_stb_o && (tmo_cnt_q != CNT_W'(TIMEOUT))) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    m_err_o = '0;
    if (abort) begin
      m_err_o[idx_q] = 1'b1;
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= BUSY;
            gnt_q   <= pick_gnt;
            idx_q   <= pick_idx;
          end
        end
        BUSY: begin
          // Release is seen one edge late; other requesters are picked on the following edge.
          if (!owner_cyc || abort) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= idx_q;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o = bus_on;
    s_stb_o = bus_on & owner_stb;
    s_we_o  = bus_on & m_we_i[idx_q];
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    if (bus_on) begin
      s_adr_o        = m_adr_i[idx_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o        = m_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
      s_sel_o        = m_sel_i[idx_q*SEL_WIDTH +: SEL_WIDTH];
      m_ack_o[idx_q] = s_ack_i & owner_stb;
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

endmodule
